// File: rtl/score_ram_slave_pkg.sv
// score_ram_slave_pkg
//   Shared definitions for the score RAM bus slave: transfer type, size and
//   response encodings, the slave FSM state enum, and helpers that decode an
//   address phase into an error flag and into write byte enables.
//   No ports (package).
package score_ram_slave_pkg;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HSIZE encodings; anything above HSIZE_WORD is illegal
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // HRESP encodings
    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_WAIT = 3'd1,
        ST_RD_DONE = 3'd2,
        ST_ERR1    = 3'd3,
        ST_ERR2    = 3'd4
    } state_e;

    // An address phase is in error when it falls outside the RAM window
    // (decoded bits above the word index), uses an illegal size, or is
    // misaligned for its size.
    function automatic logic xfer_err(input logic [15:0] addr,
                                      input logic [2:0]  size,
                                      input int unsigned depth_log2);
        logic oor;
        logic bad_size;
        logic misalign;
        oor      = (addr >> (depth_log2 + 2)) != 16'd0;
        bad_size = size > HSIZE_WORD;
        misalign = ((size == HSIZE_HALF) && addr[0]) ||
                   ((size == HSIZE_WORD) && (addr[1:0] != 2'b00));
        return oor | bad_size | misalign;
    endfunction

    // Byte-lane enables for a legal write of the given size at byte offset lo.
    function automatic logic [3:0] byte_en(input logic [2:0] size,
                                           input logic [1:0] lo);
        logic [3:0] be;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << lo;
            HSIZE_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
            default:    be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/score_ram_slave_if.sv
// score_ram_slave_if
//   Bus bundle between a master (or interconnect) and the score RAM slave.
//   Requests: HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY.
//   Responses: HRDATA, HREADYOUT, HRESP.
//
//   Handshake: an address phase is taken by the slave in a cycle where
//   HSEL=1, HREADY=1 and HTRANS is NONSEQ or SEQ. The following cycle(s) are
//   its data phase, which ends at the first rising edge where HREADY=1; while
//   HREADY=0 the master holds the next address phase and HWDATA unchanged.
interface score_ram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic [1:0]  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HREADY, HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/score_ram_core.sv
// score_ram_core
//   Single-port synchronous RAM, 2^DEPTH_LOG2 x 32 bits, byte-write enables,
//   one cycle read latency. Contents are not reset; only the read data
//   register is, so the bus sees zero read data out of reset.
//   Ports:
//     clk, rst_n  - clock, asynchronous active-low reset (read register only)
//     en_i, we_i  - access enable, write (1) / read (0)
//     be_i        - byte-lane write enables
//     addr_i      - word index
//     wdata_i     - write data
//     rdata_o     - read data, updated only by reads and held otherwise
module score_ram_core #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/score_ram_slave.sv
// score_ram_slave
//   Bus slave in front of a 2^DEPTH_LOG2-word RAM. Writes complete with no
//   wait state, reads take one wait state, and bad transfers get a two-cycle
//   ERROR response.
//   Ports:
//     clk, rst_n - clock, asynchronous active-low reset
//     bus        - slave side of score_ram_slave_if
//     state_o    - current FSM state, for observation
module score_ram_slave
    import score_ram_slave_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    score_ram_slave_if.slave bus,
    output state_e           state_o
);

    state_e                state_q, state_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            lo_q, lo_d;

    logic                  can_accept;
    logic                  accept;
    logic                  addr_err;
    logic                  hreadyout;
    logic [1:0]            hresp;
    logic                  ram_en;
    logic                  ram_we;
    logic [3:0]            ram_be;
    logic [31:0]           ram_rdata;
    logic                  unused_ok;

    // A new address phase can only be taken while the slave is driving
    // HREADYOUT=1, i.e. in the states where a data phase is ending.
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_RD_DONE) ||
                        (state_q == ST_ERR2);
    assign accept     = can_accept && bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign addr_err   = xfer_err(bus.HADDR[15:0], bus.HSIZE, DEPTH_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            wr_pend_q <= 1'b0;
            idx_q     <= '0;
            size_q    <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            wr_pend_q <= wr_pend_d;
            idx_q     <= idx_d;
            size_q    <= size_d;
            lo_q      <= lo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_pend_d = 1'b0;
        idx_d     = idx_q;
        size_d    = size_q;
        lo_d      = lo_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            ST_RD_WAIT: begin
                hreadyout = 1'b0;
                state_d   = ST_RD_DONE;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_IDLE, ST_RD_DONE, ST_ERR2: begin
                if (state_q == ST_ERR2) begin
                    hresp = HRESP_ERROR;
                end
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d  = bus.HADDR[DEPTH_LOG2+1:2];
                    size_d = bus.HSIZE;
                    lo_d   = bus.HADDR[1:0];
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (!bus.HWRITE) begin
                        state_d = ST_RD_WAIT;
                    end else begin
                        wr_pend_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A write's data phase always runs in IDLE and a read accesses the RAM
    // only in RD_WAIT, so the two never share a cycle. Reading in RD_WAIT
    // (not at the address phase) lets a read see a write committed at the
    // edge that started it.
    assign ram_we = wr_pend_q;
    assign ram_en = wr_pend_q || (state_q == ST_RD_WAIT);
    assign ram_be = byte_en(size_q, lo_q);

    score_ram_core #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (ram_be),
        .addr_i  (idx_q),
        .wdata_i (bus.HWDATA),
        .rdata_o (ram_rdata)
    );

    // The core's read register only changes on reads, so HRDATA holds the
    // last read value outside RD_DONE.
    assign bus.HRDATA    = ram_rdata;
    assign bus.HREADYOUT = hreadyout;
    assign bus.HRESP     = hresp;
    assign state_o       = state_q;

    // Upper address bits and HTRANS[0] carry no meaning for this slave.
    assign unused_ok = ^{bus.HADDR[31:16], bus.HTRANS[0]};

endmodule
